// File: rtl/qoa_frame_sequencer_if.sv
// Byte-stream input and LMS/slice output bundle between the QOA parser and its neighbours.
// The master side is the environment (SPI crossing plus decoder); the slave side is the sequencer.
interface qoa_frame_sequencer_if;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               lms_wr;
    logic [2:0]         lms_idx;
    logic signed [15:0] lms_data;
    logic               slice_valid;
    logic               slice_ready;
    logic [63:0]        slice_data;
    logic               slice_last;

    modport master (
        output in_valid, in_data, slice_ready,
        input  in_ready, lms_wr, lms_idx, lms_data, slice_valid, slice_data, slice_last
    );

    modport slave (
        input  in_valid, in_data, slice_ready,
        output in_ready, lms_wr, lms_idx, lms_data, slice_valid, slice_data, slice_last
    );
endinterface

// File: rtl/qoa_frame_sequencer.sv
// Walks a mono QOA container byte by byte: file header, frame header, LMS state, slices.
// Loads LMS registers, hands slices to the decoder and flags malformed streams.
module qoa_frame_sequencer #(
    parameter int unsigned MAX_FSAMPLES = 5120,
    parameter int unsigned SLICE_LEN    = 20
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    qoa_frame_sequencer_if.slave bus,
    output logic [23:0]          frame_samplerate,
    output logic                 frame_done,
    output logic                 stream_done,
    output logic                 error,
    output logic                 busy
);
    localparam logic [15:0] SLICE_LEN_W = 16'(SLICE_LEN);
    localparam logic [15:0] MAX_FS_W    = 16'(MAX_FSAMPLES);

    typedef enum logic [2:0] {FILE_HDR, FRAME_HDR, LMS, SLICE, SLICE_WAIT, ERR} state_e;

    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h71;
            2'd1:    return 8'h6F;
            2'd2:    return 8'h61;
            default: return 8'h66;
        endcase
    endfunction

    function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? (a - b) : 16'd0;
    endfunction

    state_e             state_q, state_d;
    logic [3:0]         byte_cnt_q, byte_cnt_d;
    logic [15:0]        frame_bytes_q, frame_bytes_d;
    logic [15:0]        samples_left_q, samples_left_d;
    logic [31:0]        total_left_q, total_left_d;
    logic [15:0]        fsamples_q, fsamples_d;
    logic [15:0]        fsize_q, fsize_d;
    logic [15:0]        hdr_q, hdr_d;
    logic [23:0]        rate_q, rate_d;
    logic [7:0]         chan_q, chan_d;
    logic [7:0]         lms_hi_q, lms_hi_d;
    logic [63:0]        slice_q, slice_d;
    logic               lms_wr_q, lms_wr_d;
    logic [2:0]         lms_idx_q, lms_idx_d;
    logic signed [15:0] lms_data_q, lms_data_d;
    logic               frame_done_q, frame_done_d;
    logic               stream_done_q, stream_done_d;

    logic in_ready_w, accept_w, last_w;

    assign in_ready_w = (state_q != SLICE_WAIT);
    assign accept_w   = bus.in_valid && in_ready_w;
    assign last_w     = (samples_left_q <= SLICE_LEN_W);

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = accept_w ? byte_cnt_q + 4'd1 : byte_cnt_q;
        frame_bytes_d  = frame_bytes_q;
        samples_left_d = samples_left_q;
        total_left_d   = total_left_q;
        fsamples_d     = fsamples_q;
        fsize_d        = fsize_q;
        hdr_d          = hdr_q;
        rate_d         = rate_q;
        chan_d         = chan_q;
        lms_hi_d       = lms_hi_q;
        slice_d        = slice_q;
        lms_wr_d       = 1'b0;
        lms_idx_d      = lms_idx_q;
        lms_data_d     = lms_data_q;
        frame_done_d   = 1'b0;
        stream_done_d  = 1'b0;

        case (state_q)
            FILE_HDR: if (accept_w) begin
                if (byte_cnt_q < 4'd4) begin
                    if (bus.in_data != magic_byte(byte_cnt_q[1:0])) state_d = ERR;
                end else begin
                    total_left_d = {total_left_q[23:0], bus.in_data};
                    if (byte_cnt_q == 4'd7) state_d = (total_left_d == 32'd0) ? ERR : FRAME_HDR;
                end
            end
            FRAME_HDR: if (accept_w) begin
                frame_bytes_d = frame_bytes_q + 16'd1;
                case (byte_cnt_q)
                    4'd0:       chan_d     = bus.in_data;
                    4'd1, 4'd2: hdr_d      = {hdr_q[7:0], bus.in_data};
                    4'd3:       rate_d     = {hdr_q, bus.in_data};
                    4'd4, 4'd5: fsamples_d = {fsamples_q[7:0], bus.in_data};
                    4'd6:       fsize_d    = {fsize_q[7:0], bus.in_data};
                    default: begin
                        fsize_d        = {fsize_q[7:0], bus.in_data};
                        samples_left_d = fsamples_q;
                        if (chan_q != 8'd1 || fsamples_q == 16'd0 || fsamples_q > MAX_FS_W ||
                            {16'd0, fsamples_q} > total_left_q)
                            state_d = ERR;
                        else
                            state_d = LMS;
                    end
                endcase
            end
            LMS: if (accept_w) begin
                frame_bytes_d = frame_bytes_q + 16'd1;
                if (!byte_cnt_q[0]) begin
                    lms_hi_d = bus.in_data;
                end else begin
                    lms_wr_d   = 1'b1;
                    lms_idx_d  = byte_cnt_q[3:1];
                    lms_data_d = signed'({lms_hi_q, bus.in_data});
                end
                if (byte_cnt_q == 4'd15) state_d = SLICE;
            end
            SLICE: if (accept_w) begin
                frame_bytes_d = frame_bytes_q + 16'd1;
                slice_d       = {slice_q[55:0], bus.in_data};
                if (byte_cnt_q == 4'd7) state_d = SLICE_WAIT;
            end
            SLICE_WAIT: if (bus.slice_ready) begin
                samples_left_d = sat_sub(samples_left_q, SLICE_LEN_W);
                if (!last_w) begin
                    state_d = SLICE;
                end else if (frame_bytes_q != fsize_q) begin
                    state_d = ERR;
                end else begin
                    frame_done_d = 1'b1;
                    total_left_d = total_left_q - {16'd0, fsamples_q};
                    if (total_left_d == 32'd0) begin
                        stream_done_d = 1'b1;
                        state_d       = FILE_HDR;
                    end else begin
                        state_d = FRAME_HDR;
                    end
                end
            end
            ERR:     state_d = ERR;
            default: state_d = FILE_HDR;
        endcase

        // Every state entry restarts its byte count; a new frame restarts the frame size tally.
        if (state_d != state_q) byte_cnt_d = 4'd0;
        if (state_d == FRAME_HDR && state_q != FRAME_HDR) frame_bytes_d = 16'd0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q        <= FILE_HDR;
            byte_cnt_q     <= 4'd0;
            frame_bytes_q  <= 16'd0;
            samples_left_q <= 16'd0;
            total_left_q   <= 32'd0;
            fsamples_q     <= 16'd0;
            fsize_q        <= 16'd0;
            hdr_q          <= 16'd0;
            rate_q         <= 24'd0;
            chan_q         <= 8'd0;
            lms_hi_q       <= 8'd0;
            slice_q        <= 64'd0;
            lms_wr_q       <= 1'b0;
            lms_idx_q      <= 3'd0;
            lms_data_q     <= 16'sd0;
            frame_done_q   <= 1'b0;
            stream_done_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            frame_bytes_q  <= frame_bytes_d;
            samples_left_q <= samples_left_d;
            total_left_q   <= total_left_d;
            fsamples_q     <= fsamples_d;
            fsize_q        <= fsize_d;
            hdr_q          <= hdr_d;
            rate_q         <= rate_d;
            chan_q         <= chan_d;
            lms_hi_q       <= lms_hi_d;
            slice_q        <= slice_d;
            lms_wr_q       <= lms_wr_d;
            lms_idx_q      <= lms_idx_d;
            lms_data_q     <= lms_data_d;
            frame_done_q   <= frame_done_d;
            stream_done_q  <= stream_done_d;
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.lms_wr      = lms_wr_q;
    assign bus.lms_idx     = lms_idx_q;
    assign bus.lms_data    = lms_data_q;
    assign bus.slice_valid = (state_q == SLICE_WAIT);
    assign bus.slice_data  = slice_q;
    assign bus.slice_last  = (state_q == SLICE_WAIT) && last_w;
    assign frame_samplerate = rate_q;
    assign frame_done       = frame_done_q;
    assign stream_done      = stream_done_q;
    assign error            = (state_q == ERR);
    assign busy             = !(state_q == FILE_HDR && byte_cnt_q == 4'd0);
endmodule

// File: tb/tb_qoa_frame_sequencer.sv
// Randomised bench for qoa_frame_sequencer: streams are built from frame descriptions and the
// expected LMS writes, slices and frame events come from the container rules, not the RTL.
module tb_qoa_frame_sequencer;
    localparam logic [31:0] MAGIC = 32'h716F6166;
    localparam int NOLIM = 1 << 30;

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    qoa_frame_sequencer_if bus();
    logic [23:0] frame_samplerate;
    logic        frame_done, stream_done, error, busy;

    qoa_frame_sequencer #(.MAX_FSAMPLES(5120), .SLICE_LEN(20)) dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .bus              (bus),
        .frame_samplerate (frame_samplerate),
        .frame_done       (frame_done),
        .stream_done      (stream_done),
        .error            (error),
        .busy             (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  stream_q[$];
    logic [18:0] exp_lms[$];
    logic [64:0] exp_slc[$];
    logic [24:0] exp_fd[$];
    logic        dead, exp_err;
    logic [31:0] model_total;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        sys_rst          = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_data      = 8'h00;
        bus.slice_ready  = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        stream_q.delete();
        exp_lms.delete();
        exp_slc.delete();
        exp_fd.delete();
        dead        = 1'b0;
        exp_err     = 1'b0;
        model_total = 32'd0;
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge sys_clk);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_strobes"}, {bus.lms_wr, bus.slice_valid, bus.slice_last, frame_done, stream_done}, 0);
        chk({tag, "_data"}, {bus.lms_idx, bus.lms_data, frame_samplerate}, 0);
        chk({tag, "_slice_data"}, bus.slice_data, 0);
    endtask

    task automatic add_file_hdr(input logic [31:0] magic, input logic [31:0] total);
        for (int b = 3; b >= 0; b--) stream_q.push_back(magic[b*8 +: 8]);
        for (int b = 3; b >= 0; b--) stream_q.push_back(total[b*8 +: 8]);
        model_total = total;
        if (magic != MAGIC || total == 32'd0) begin
            dead    = 1'b1;
            exp_err = 1'b1;
        end
    endtask

    task automatic add_frame(input int fsamp, input int chan, input logic [23:0] rate,
                             input int fsize_adj, input bit fixed);
        int n;
        logic [15:0] fs, fsz, v;
        logic [63:0] d;
        logic ok;
        n   = (fsamp + 19) / 20;
        fs  = 16'(fsamp);
        fsz = 16'(24 + 8 * n + fsize_adj);
        stream_q.push_back(8'(chan));
        stream_q.push_back(rate[23:16]);
        stream_q.push_back(rate[15:8]);
        stream_q.push_back(rate[7:0]);
        stream_q.push_back(fs[15:8]);
        stream_q.push_back(fs[7:0]);
        stream_q.push_back(fsz[15:8]);
        stream_q.push_back(fsz[7:0]);
        ok = !dead && chan == 1 && fsamp > 0 && fsamp <= 5120 && 32'(fsamp) <= model_total;
        if (!dead && !ok) begin
            dead    = 1'b1;
            exp_err = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            v = fixed ? 16'(i + 1) : 16'($urandom);
            stream_q.push_back(v[15:8]);
            stream_q.push_back(v[7:0]);
            if (ok) exp_lms.push_back({3'(i), v});
        end
        for (int s = 0; s < n; s++) begin
            d = fixed ? 64'h123456789ABCDEF0 : {$urandom, $urandom};
            for (int b = 7; b >= 0; b--) stream_q.push_back(d[b*8 +: 8]);
            if (ok) exp_slc.push_back({s == n - 1, d});
        end
        if (ok) begin
            if (fsize_adj != 0) begin
                dead    = 1'b1;
                exp_err = 1'b1;
            end else begin
                model_total -= 32'(fsamp);
                exp_fd.push_back({model_total == 32'd0, rate});
            end
        end
    endtask

    task automatic add_garbage(input int n);
        for (int i = 0; i < n; i++) stream_q.push_back(8'($urandom));
    endtask

    // rdy_mode: 0 = slice_ready tied high, 1 = random, 2 = hold low 10 cycles per slice
    task automatic run(input int gap_pct, input int rdy_mode, input int byte_limit);
        int cyc = 0, acc = 0, tail = 0, stall_cnt = 0;
        logic acc_now, hs, prev_hs = 1'b0;
        logic [64:0] es;
        logic [24:0] ef;
        forever begin
            @(negedge sys_clk);
            acc_now = bus.in_valid && bus.in_ready;
            hs      = bus.slice_valid && bus.slice_ready;
            if (bus.lms_wr) begin
                if (exp_lms.size() == 0) chk("lms_spurious", bus.lms_wr, 0);
                else chk("lms_write", {bus.lms_idx, bus.lms_data}, exp_lms.pop_front());
            end
            if (bus.slice_valid) chk("slice_wait_in_ready", bus.in_ready, 0);
            if (hs) begin
                if (exp_slc.size() == 0) chk("slice_spurious", bus.slice_valid, 0);
                else begin
                    es = exp_slc.pop_front();
                    chk("slice", {bus.slice_last, bus.slice_data}, es);
                end
            end
            if (prev_hs) begin
                chk("post_hs_in_ready", bus.in_ready, 1);
                if (rdy_mode == 2 && stream_q.size() > 0)
                    chk("resume_accept", bus.in_valid & bus.in_ready, 1);
            end
            if (frame_done) begin
                chk("frame_done_after_hs", prev_hs, 1);
                if (exp_fd.size() == 0) chk("frame_done_spurious", frame_done, 0);
                else begin
                    ef = exp_fd.pop_front();
                    chk("stream_done", stream_done, ef[24]);
                    chk("samplerate", frame_samplerate, ef[23:0]);
                end
            end else if (stream_done) begin
                chk("stream_done_spurious", stream_done, 0);
            end
            prev_hs = hs;

            @(posedge sys_clk);
            #1;
            if (acc_now) begin
                void'(stream_q.pop_front());
                acc++;
                bus.in_valid = 1'b0;
            end
            if (!bus.in_valid && stream_q.size() > 0 && acc < byte_limit &&
                $urandom_range(99) >= gap_pct) begin
                bus.in_valid = 1'b1;
                bus.in_data  = stream_q[0];
            end
            case (rdy_mode)
                0: bus.slice_ready = 1'b1;
                1: bus.slice_ready = 1'($urandom_range(1));
                default: begin
                    if (bus.slice_valid) begin
                        bus.slice_ready = (stall_cnt >= 10);
                        stall_cnt++;
                    end else begin
                        bus.slice_ready = 1'b0;
                        stall_cnt       = 0;
                    end
                end
            endcase
            cyc++;
            if ((stream_q.size() == 0 || acc >= byte_limit) && !bus.in_valid &&
                (acc >= byte_limit || (exp_lms.size() == 0 && exp_slc.size() == 0 && exp_fd.size() == 0)))
                tail++;
            if (tail >= 6) break;
            if (cyc >= 5000) begin
                chk("run_timeout_pending", exp_lms.size() + exp_slc.size() + exp_fd.size() + stream_q.size(), 0);
                break;
            end
        end
        bus.in_valid    = 1'b0;
        bus.slice_ready = 1'b0;
    endtask

    task automatic finish_checks(input string tag);
        @(negedge sys_clk);
        chk({tag, "_error"}, error, exp_err);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_busy"}, busy, exp_err);
        chk({tag, "_pending"}, exp_lms.size() + exp_slc.size() + exp_fd.size(), 0);
    endtask

    initial begin
        int nf, tot;
        int fsv[3];
        sys_rst         = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_data     = 8'h00;
        bus.slice_ready = 1'b0;
        do_reset();
        check_reset_vals("reset");

        add_file_hdr(MAGIC, 20);
        add_frame(20, 1, 24'd44100, 0, 1'b1);
        run(0, 0, NOLIM);
        finish_checks("minimal");

        do_reset();
        add_file_hdr(MAGIC, 45);
        add_frame(45, 1, 24'd22050, 0, 1'b0);
        run(20, 1, NOLIM);
        finish_checks("three_slices");

        do_reset();
        add_file_hdr(MAGIC, 60);
        add_frame(60, 1, 24'd32000, 0, 1'b0);
        run(0, 2, NOLIM);
        finish_checks("stall");

        do_reset();
        add_file_hdr(32'h716F6167, 20);
        add_frame(20, 1, 24'd44100, 0, 1'b0);
        add_garbage(10);
        run(10, 1, NOLIM);
        finish_checks("bad_magic");

        do_reset();
        add_file_hdr(MAGIC, 20);
        add_frame(20, 2, 24'd44100, 0, 1'b0);
        add_garbage(10);
        run(10, 1, NOLIM);
        finish_checks("bad_channels");

        do_reset();
        add_file_hdr(MAGIC, 20);
        add_frame(20, 1, 24'd44100, 8, 1'b0);
        add_garbage(10);
        run(10, 1, NOLIM);
        finish_checks("bad_fsize");

        do_reset();
        add_file_hdr(MAGIC, 40);
        add_frame(20, 1, 24'd44100, 0, 1'b0);
        add_frame(20, 1, 24'd48000, 0, 1'b0);
        run(10, 1, NOLIM);
        finish_checks("two_frames");

        do_reset();
        add_file_hdr(MAGIC, 20);
        add_frame(20, 1, 24'd44100, 0, 1'b0);
        run(0, 0, 25);
        chk("mid_lms_pending_writes", exp_lms.size(), 4);
        do_reset();
        check_reset_vals("mid_reset");
        add_file_hdr(MAGIC, 20);
        add_frame(20, 1, 24'd44100, 0, 1'b1);
        run(0, 0, NOLIM);
        finish_checks("after_reset");

        for (int k = 0; k < 6; k++) begin
            do_reset();
            nf  = $urandom_range(1, 3);
            tot = 0;
            for (int f = 0; f < nf; f++) begin
                fsv[f] = $urandom_range(1, 130);
                tot += fsv[f];
            end
            add_file_hdr(32'(tot), 32'(tot));
            exp_err = 1'b0;
            dead    = 1'b0;
            stream_q.delete();
            add_file_hdr(MAGIC, 32'(tot));
            for (int f = 0; f < nf; f++)
                add_frame(fsv[f], 1, 24'($urandom_range(8000, 96000)), 0, 1'b0);
            run($urandom_range(0, 40), $urandom_range(0, 1), NOLIM);
            finish_checks("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
